// File: rtl/move_scheduler_if.sv
// Move request handshake between the step scheduler and the snake body engine.
// The master raises move_req with a heading and holds both until move_ack.
interface move_scheduler_if;
    logic       move_req;
    logic [1:0] move_dir;
    logic       move_ack;

    modport master (
        output move_req,
        output move_dir,
        input  move_ack
    );

    modport slave (
        input  move_req,
        input  move_dir,
        output move_ack
    );
endinterface

// File: rtl/move_scheduler.sv
// Snake game pacing: counts frames, buffers two pending turns and issues
// one move request per step, speeding up as apples are eaten.
module move_scheduler #(
    parameter int TICK_FRAMES   = 8,
    parameter int MIN_FRAMES    = 2,
    parameter int SPEEDUP_EVERY = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_start,
    input  logic                i_frame_start,
    input  logic                i_turn_valid,
    input  logic [1:0]          i_turn_dir,
    input  logic                i_grow,
    input  logic                i_game_over,
    output logic [7:0]          o_frames_per_step,
    output logic [15:0]         o_step_count,
    output logic                o_running,
    move_scheduler_if.master    mv
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RUN_WAIT = 2'd1;
    localparam logic [1:0] S_ISSUE    = 2'd2;
    localparam logic [1:0] S_HALT     = 2'd3;

    localparam logic [7:0] TICK8 = 8'(TICK_FRAMES);
    localparam logic [7:0] MIN8  = 8'(MIN_FRAMES);
    localparam logic [7:0] SPD8  = 8'(SPEEDUP_EVERY);
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    logic [1:0]  r_state;
    logic        r_move_req;
    logic [1:0]  r_move_dir;
    logic [7:0]  r_fps;
    logic [15:0] r_step_count;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  r_apple_cnt;
    logic [1:0]  r_q0;
    logic [1:0]  r_q1;
    logic [1:0]  r_q_cnt;

    logic        w_active;
    logic        w_live;
    logic [1:0]  w_ref;
    logic        w_turn_ok;
    logic        w_frame_hit;
    logic        w_tick;
    logic        w_pop;
    logic        w_ack;
    logic        w_grow;
    logic        w_apple_wrap;
    logic [7:0]  w_fps_dec;
    logic [1:0]  w_push_slot;

    assign w_active = (r_state == S_RUN_WAIT) || (r_state == S_ISSUE);
    // game_over suppresses every other event in the same cycle
    assign w_live   = w_active && !i_game_over;

    assign w_ref = (r_q_cnt == 2'd2) ? r_q1 :
                   (r_q_cnt == 2'd1) ? r_q0 : r_move_dir;

    assign w_turn_ok = w_live && i_turn_valid
                    && (i_turn_dir != w_ref)
                    && (i_turn_dir != (w_ref ^ 2'd2))
                    && (r_q_cnt != 2'd2);

    assign w_frame_hit  = i_frame_start && ((r_frame_cnt + 8'd1) == r_fps);
    assign w_tick       = w_live && (r_state == S_RUN_WAIT) && w_frame_hit;
    assign w_pop        = w_tick && (r_q_cnt != 2'd0);
    assign w_ack        = w_live && (r_state == S_ISSUE) && mv.move_ack;
    assign w_grow       = w_live && i_grow;
    assign w_apple_wrap = (r_apple_cnt + 8'd1) == SPD8;
    assign w_fps_dec    = (r_fps > MIN8) ? (r_fps - 8'd1) : MIN8;
    assign w_push_slot  = r_q_cnt - {1'b0, w_pop};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_move_req   <= 1'b0;
            r_move_dir   <= DIR_RIGHT;
            r_fps        <= TICK8;
            r_step_count <= 16'd0;
            r_frame_cnt  <= 8'd0;
            r_apple_cnt  <= 8'd0;
            r_q0         <= 2'd0;
            r_q1         <= 2'd0;
            r_q_cnt      <= 2'd0;
        end else if (((r_state == S_IDLE) || (r_state == S_HALT)) && i_start) begin
            r_state      <= S_RUN_WAIT;
            r_move_req   <= 1'b0;
            r_move_dir   <= DIR_RIGHT;
            r_fps        <= TICK8;
            r_step_count <= 16'd0;
            r_frame_cnt  <= 8'd0;
            r_apple_cnt  <= 8'd0;
            r_q_cnt      <= 2'd0;
        end else if (w_active && i_game_over) begin
            r_state    <= S_HALT;
            r_move_req <= 1'b0;
        end else if (w_live) begin
            if ((r_state == S_RUN_WAIT) && i_frame_start) begin
                if (w_frame_hit) begin
                    r_frame_cnt <= 8'd0;
                    r_state     <= S_ISSUE;
                    r_move_req  <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end

            if (w_ack) begin
                r_step_count <= r_step_count + 16'd1;
                r_move_req   <= 1'b0;
                r_state      <= S_RUN_WAIT;
            end

            // pop shifts the queue; a same-cycle push lands in the freed slot
            if (w_pop) begin
                r_move_dir <= r_q0;
                r_q0       <= r_q1;
            end
            if (w_turn_ok) begin
                if (w_push_slot == 2'd0) r_q0 <= i_turn_dir;
                else                     r_q1 <= i_turn_dir;
            end
            r_q_cnt <= r_q_cnt + {1'b0, w_turn_ok} - {1'b0, w_pop};

            if (w_grow) begin
                if (w_apple_wrap) begin
                    r_apple_cnt <= 8'd0;
                    r_fps       <= w_fps_dec;
                end else begin
                    r_apple_cnt <= r_apple_cnt + 8'd1;
                end
            end
        end
    end

    assign mv.move_req       = r_move_req;
    assign mv.move_dir       = r_move_dir;
    assign o_frames_per_step = r_fps;
    assign o_step_count      = r_step_count;
    assign o_running         = w_active;

endmodule
